// File: rtl/gray_rr_sched.sv
// gray_rr_sched: round-robin owner of one shared 3-bit Gray step counter.
// Each granted requester gets a session: clear the counter, run its step
// count of enabled cycles, then report the final code and the wrap count.
// Optional build macro: GRAY_STEP_CHECK_EN adds a sticky Gray-step checker
// on Err; without it Err is tied low.
// Ports:
//   Clk, Reset           clock, synchronous active-low reset
//   Req, Steps           per-requester level request and step count
//   Grant, Done          one-hot owner, one-cycle end-of-session pulse
//   Final_Code, Wraps    counter code and 100->000 wrap count of last session
//   Busy                 high whenever not idle
//   Cnt_En, Cnt_Clr      drive the counter En and active-high Reset
//   Cnt_Value            counter Output
//   Cnt_Overflow         counter Overflow (not used for sequencing)
//   Err                  sticky Gray-step error
module gray_rr_sched #(
    parameter int NREQ  = 4,
    parameter int STEPW = 5
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [NREQ-1:0]       Req,
    input  logic [NREQ*STEPW-1:0] Steps,
    output logic [NREQ-1:0]       Grant,
    output logic [NREQ-1:0]       Done,
    output logic [2:0]            Final_Code,
    output logic [STEPW-1:0]      Wraps,
    output logic                  Busy,
    output logic                  Cnt_En,
    output logic                  Cnt_Clr,
    input  logic [2:0]            Cnt_Value,
    input  logic                  Cnt_Overflow,
    output logic                  Err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    own;
    logic [STEPW-1:0] rem;

    logic             found;
    logic [PW-1:0]    win;
    logic [PW-1:0]    idx;

    // Overflow is informational only; the session length comes from rem.
    logic ovf_unused;
    assign ovf_unused = Cnt_Overflow;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] o);
        return (int'(o) == NREQ - 1) ? '0 : o + 1'b1;
    endfunction

    // First requester found scanning upward from the round-robin pointer.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = PW'((int'(ptr) + i) % NREQ);
            if (!found && Req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state      <= S_IDLE;
            ptr        <= '0;
            own        <= '0;
            rem        <= '0;
            Grant      <= '0;
            Done       <= '0;
            Final_Code <= '0;
            Wraps      <= '0;
            Busy       <= 1'b0;
            Cnt_En     <= 1'b0;
            Cnt_Clr    <= 1'b1;
        end else begin
            Done    <= '0;
            Cnt_Clr <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (found) begin
                        own     <= win;
                        rem     <= Steps[int'(win)*STEPW +: STEPW];
                        Grant   <= NREQ'(1) << win;
                        Cnt_Clr <= 1'b1;
                        Wraps   <= '0;
                        Busy    <= 1'b1;
                        state   <= S_CLR;
                    end
                end
                S_CLR: begin
                    if (!Req[own]) begin
                        Grant <= '0;
                        Busy  <= 1'b0;
                        ptr   <= nxt(own);
                        state <= S_IDLE;
                    end else if (rem == '0) begin
                        Done  <= Grant;
                        state <= S_DONE;
                    end else begin
                        Cnt_En <= 1'b1;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!Req[own]) begin
                        // Abort: the step in flight this cycle still lands.
                        Cnt_En <= 1'b0;
                        Grant  <= '0;
                        Busy   <= 1'b0;
                        ptr    <= nxt(own);
                        state  <= S_IDLE;
                    end else begin
                        if (Cnt_Value == 3'b100) begin
                            Wraps <= Wraps + 1'b1;
                        end
                        if (rem == STEPW'(1)) begin
                            Cnt_En <= 1'b0;
                            Done   <= Grant;
                            state  <= S_DONE;
                        end else begin
                            rem <= rem - 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    // The last enabled edge has landed, so Cnt_Value is final.
                    Final_Code <= Cnt_Value;
                    Grant      <= '0;
                    Busy       <= 1'b0;
                    ptr        <= nxt(own);
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef GRAY_STEP_CHECK_EN
    logic [2:0] prev;
    logic       first;

    // The first RUN cycle must see the cleared code; every later RUN cycle
    // must differ from the previous one in exactly one bit.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            Err   <= 1'b0;
            prev  <= '0;
            first <= 1'b0;
        end else if (state == S_CLR) begin
            first <= 1'b1;
        end else if (state == S_RUN) begin
            first <= 1'b0;
            prev  <= Cnt_Value;
            if (first) begin
                if (Cnt_Value != 3'b000) begin
                    Err <= 1'b1;
                end
            end else if ($countones(Cnt_Value ^ prev) != 1) begin
                Err <= 1'b1;
            end
        end
    end
`else
    assign Err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_rr_sched.sv
// Self-checking bench for gray_rr_sched with a behavioural Gray counter
// attached and expectations derived from session arithmetic.
module tb_gray_rr_sched;

    localparam int NREQ  = 4;
    localparam int STEPW = 5;

    logic                  Clk = 1'b0;
    logic                  Reset = 1'b0;
    logic [NREQ-1:0]       Req = '0;
    logic [NREQ*STEPW-1:0] Steps = '0;
    logic [NREQ-1:0]       Grant;
    logic [NREQ-1:0]       Done;
    logic [2:0]            Final_Code;
    logic [STEPW-1:0]      Wraps;
    logic                  Busy;
    logic                  Cnt_En;
    logic                  Cnt_Clr;
    logic [2:0]            Cnt_Value;
    logic                  Cnt_Overflow;
    logic                  Err;

    int checks = 0;
    int failures = 0;

    int          model_ptr = 0;
    logic [2:0]  last_final = 3'b000;

    int unsigned cnt_n = 0;
    int unsigned en_edges = 0;
    logic        ovf = 1'b0;
    logic        force_on = 1'b0;
    logic [2:0]  force_val = 3'b000;

    gray_rr_sched #(.NREQ(NREQ), .STEPW(STEPW)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Req(Req),
        .Steps(Steps),
        .Grant(Grant),
        .Done(Done),
        .Final_Code(Final_Code),
        .Wraps(Wraps),
        .Busy(Busy),
        .Cnt_En(Cnt_En),
        .Cnt_Clr(Cnt_Clr),
        .Cnt_Value(Cnt_Value),
        .Cnt_Overflow(Cnt_Overflow),
        .Err(Err)
    );

    always #5 Clk = ~Clk;

    function automatic logic [2:0] gray3(input int unsigned n);
        logic [2:0] b;
        b = 3'(n % 8);
        return b ^ (b >> 1);
    endfunction

    function automatic int rr_pick(input logic [3:0] m, input int p);
        for (int i = 0; i < NREQ; i++) begin
            if (m[(p + i) % NREQ]) return (p + i) % NREQ;
        end
        return -1;
    endfunction

    // Counter the scheduler drives: synchronous clear, Gray step on enable.
    always @(posedge Clk) begin
        if (Cnt_Clr) begin
            cnt_n <= 0;
            ovf   <= 1'b0;
        end else if (Cnt_En) begin
            cnt_n    <= cnt_n + 1;
            en_edges <= en_edges + 1;
            if (gray3(cnt_n) == 3'b100) ovf <= 1'b1;
        end
    end

    assign Cnt_Value    = force_on ? force_val : gray3(cnt_n);
    assign Cnt_Overflow = ovf;

    task automatic do_reset();
        Reset = 1'b0;
        Req   = '0;
        force_on = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        model_ptr  = 0;
        last_final = 3'b000;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        Req   = '0;
        repeat (2) @(negedge Clk);
        checks++; if (Grant !== 4'b0) begin failures++; $display("FAIL rst_grant got=%b exp=0000", Grant); end
        checks++; if (Done !== 4'b0) begin failures++; $display("FAIL rst_done got=%b exp=0000", Done); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", Busy); end
        checks++; if (Cnt_En !== 1'b0) begin failures++; $display("FAIL rst_en got=%b exp=0", Cnt_En); end
        checks++; if (Cnt_Clr !== 1'b1) begin failures++; $display("FAIL rst_clr got=%b exp=1", Cnt_Clr); end
        checks++; if (Final_Code !== 3'b0) begin failures++; $display("FAIL rst_final got=%b exp=000", Final_Code); end
        checks++; if (Wraps !== 5'd0) begin failures++; $display("FAIL rst_wraps got=%0d exp=0", Wraps); end
        checks++; if (Err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", Err); end
        Reset = 1'b1;
        @(negedge Clk);
        checks++; if (Cnt_Clr !== 1'b0) begin failures++; $display("FAIL idle_clr got=%b exp=0", Cnt_Clr); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", Busy); end
        model_ptr  = 0;
        last_final = 3'b000;
    endtask

    // One full session; caller sits at a negedge with the DUT idle.
    task automatic test_session(input string nm, input logic [3:0] mask,
                                input logic [19:0] st);
        int w;
        int s;
        int g;
        int d;
        int unsigned base;
        logic [3:0] oh;
        w  = rr_pick(mask, model_ptr);
        s  = int'(st[w*STEPW +: STEPW]);
        oh = 4'(1 << w);
        Steps = st;
        Req   = mask;
        base  = en_edges;
        g = 0;
        do begin
            @(negedge Clk);
            g++;
        end while (Grant == 4'b0 && g < 5);
        checks++; if (g !== 1) begin failures++; $display("FAIL %s grant_lat got=%0d exp=1", nm, g); end
        checks++; if (Grant !== oh) begin failures++; $display("FAIL %s grant got=%b exp=%b", nm, Grant, oh); end
        checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL %s busy got=%b exp=1", nm, Busy); end
        d = 0;
        while (Done == 4'b0 && d < s + 10) begin
            @(negedge Clk);
            d++;
        end
        checks++; if (d !== s + 1) begin failures++; $display("FAIL %s done_lat got=%0d exp=%0d", nm, d, s + 1); end
        checks++; if (Done !== oh) begin failures++; $display("FAIL %s done got=%b exp=%b", nm, Done, oh); end
        checks++; if (en_edges - base !== s) begin failures++; $display("FAIL %s en_edges got=%0d exp=%0d", nm, en_edges - base, s); end
        checks++; if (Wraps !== 5'((s / 8) % 32)) begin failures++; $display("FAIL %s wraps got=%0d exp=%0d", nm, Wraps, (s / 8) % 32); end
        checks++; if (Err !== 1'b0) begin failures++; $display("FAIL %s err got=%b exp=0", nm, Err); end
        Req = '0;
        @(negedge Clk);
        checks++; if (Final_Code !== gray3(s)) begin failures++; $display("FAIL %s final got=%b exp=%b", nm, Final_Code, gray3(s)); end
        checks++; if (Grant !== 4'b0 || Busy !== 1'b0 || Done !== 4'b0) begin failures++; $display("FAIL %s idle got=%b/%b/%b exp=0000/0/0000", nm, Grant, Busy, Done); end
        model_ptr  = (w + 1) % NREQ;
        last_final = gray3(s);
    endtask

    task automatic test_short();
        test_session("short", 4'b0001, 20'd3);
    endtask

    task automatic test_long();
        test_session("long", 4'b0001, 20'd17);
    endtask

    task automatic test_zero();
        test_session("zero", 4'b0001, 20'd0);
    endtask

    task automatic test_random();
        logic [3:0]  m;
        logic [19:0] st;
        for (int k = 0; k < 10; k++) begin
            m  = 4'($urandom_range(1, 15));
            st = 20'($urandom);
            test_session("rand", m, st);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        int g;
        int d;
        logic [3:0] oh;
        do_reset();
        Steps = {4{5'd1}};
        Req   = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            w  = rr_pick(4'b1111, model_ptr);
            oh = 4'(1 << w);
            g = 0;
            do begin
                @(negedge Clk);
                g++;
            end while (Grant == 4'b0 && g < 6);
            checks++; if (g !== ((k == 0) ? 1 : 2)) begin failures++; $display("FAIL b2b_gap k=%0d got=%0d exp=%0d", k, g, (k == 0) ? 1 : 2); end
            checks++; if (Grant !== oh) begin failures++; $display("FAIL b2b_grant k=%0d got=%b exp=%b", k, Grant, oh); end
            d = 0;
            while (Done == 4'b0 && d < 8) begin
                @(negedge Clk);
                d++;
            end
            checks++; if (d !== 2) begin failures++; $display("FAIL b2b_done k=%0d got=%0d exp=2", k, d); end
            model_ptr  = (w + 1) % NREQ;
            last_final = gray3(1);
        end
        Req = '0;
        @(negedge Clk);
        checks++; if (Grant !== 4'b0 || Busy !== 1'b0) begin failures++; $display("FAIL b2b_end got=%b/%b exp=0000/0", Grant, Busy); end
    endtask

    task automatic test_abort();
        int g;
        int unsigned base;
        logic seen;
        Steps = 20'(6 << STEPW);
        Req   = 4'b0010;
        base  = en_edges;
        g = 0;
        do begin
            @(negedge Clk);
            g++;
        end while (Grant == 4'b0 && g < 5);
        checks++; if (Grant !== 4'b0010) begin failures++; $display("FAIL abort_grant got=%b exp=0010", Grant); end
        repeat (2) @(negedge Clk);
        checks++; if (Cnt_En !== 1'b1) begin failures++; $display("FAIL abort_run_en got=%b exp=1", Cnt_En); end
        Req = '0;
        @(negedge Clk);
        checks++; if (Cnt_En !== 1'b0) begin failures++; $display("FAIL abort_en got=%b exp=0", Cnt_En); end
        checks++; if (Grant !== 4'b0 || Busy !== 1'b0) begin failures++; $display("FAIL abort_idle got=%b/%b exp=0000/0", Grant, Busy); end
        checks++; if (Final_Code !== last_final) begin failures++; $display("FAIL abort_final got=%b exp=%b", Final_Code, last_final); end
        checks++; if (en_edges - base !== 2) begin failures++; $display("FAIL abort_edges got=%0d exp=2", en_edges - base); end
        seen = (Done != 4'b0);
        repeat (3) begin
            @(negedge Clk);
            if (Done != 4'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_done got=1 exp=0"); end
        model_ptr = 2;
        test_session("abort_next", 4'b0110, 20'($urandom));
    endtask

    task automatic test_reset_mid();
        Steps = 20'd10;
        Req   = 4'b0001;
        repeat (4) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        checks++; if (Grant !== 4'b0 || Busy !== 1'b0 || Cnt_En !== 1'b0) begin failures++; $display("FAIL mid_rst got=%b/%b/%b exp=0000/0/0", Grant, Busy, Cnt_En); end
        checks++; if (Cnt_Clr !== 1'b1 || Done !== 4'b0) begin failures++; $display("FAIL mid_rst_clr got=%b/%b exp=1/0000", Cnt_Clr, Done); end
        checks++; if (Final_Code !== 3'b0 || Wraps !== 5'd0) begin failures++; $display("FAIL mid_rst_out got=%b/%0d exp=000/0", Final_Code, Wraps); end
        Req   = '0;
        Reset = 1'b1;
        @(negedge Clk);
        model_ptr  = 0;
        last_final = 3'b000;
        test_session("after_rst", 4'b1000, 20'($urandom));
    endtask

`ifdef GRAY_STEP_CHECK_EN
    task automatic test_err();
        int d;
        Steps = 20'd6;
        Req   = 4'b0001;
        @(negedge Clk);
        repeat (3) @(negedge Clk);
        force_val = 3'b010;
        force_on  = 1'b1;
        @(negedge Clk);
        force_on  = 1'b0;
        checks++; if (Err !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", Err); end
        d = 0;
        while (Done == 4'b0 && d < 12) begin
            @(negedge Clk);
            d++;
        end
        Req = '0;
        repeat (2) @(negedge Clk);
        checks++; if (Err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", Err); end
        do_reset();
        checks++; if (Err !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", Err); end
    endtask
`endif

    initial begin
        test_reset();
        test_short();
        test_long();
        test_back_to_back();
        test_abort();
        test_zero();
        test_random();
        test_reset_mid();
`ifdef GRAY_STEP_CHECK_EN
        test_err();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
